// File: rtl/chimp_pkg.sv
// Shared definitions for the chimp memory-game controller.
// Holds the FSM state enum (its values are the oState encoding), the
// default parameter values and the internal timer width.
package chimp_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 4'd0,
        ST_CLEAR      = 4'd1,
        ST_LOAD       = 4'd2,
        ST_SHOW       = 4'd3,
        ST_HIDDEN     = 4'd4,
        ST_RESULT     = 4'd5,
        ST_ROUND_WIN  = 4'd6,
        ST_ROUND_FAIL = 4'd7,
        ST_GAME_OVER  = 4'd8
    } state_e;

    localparam int unsigned DEF_START_LEVEL    = 4;
    localparam int unsigned DEF_MAX_LEVEL      = 25;
    localparam int unsigned DEF_MAX_STRIKES    = 3;
    localparam int unsigned DEF_LOAD_TIMEOUT   = 1024;
    localparam int unsigned DEF_RESULT_TIMEOUT = 8;

    // Shared LOAD/RESULT dwell counter; wide enough for any sane timeout.
    localparam int unsigned TIMER_W = 16;

endpackage

// File: rtl/chimp_edge_detect.sv
// 1-bit rising-edge detector with asynchronous active-low reset.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   d_i    - raw level input
//   rise_o - high for the cycle in which d_i is 1 and was 0 last cycle
// The detector stays disarmed for the first cycle after reset release so
// an input that is already high at release is not mistaken for an edge.
module chimp_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= d_i;
            armed_q <= 1'b1;
        end
    end

    assign rise_o = armed_q & d_i & ~prev_q;

endmodule

// File: rtl/chimp_take2_control.sv
// Round/level controller for the chimp memory game.
// Sequences board clear, load, show and hidden phases, gates player clicks
// to the datapath, reacts to the datapath's correct/wrong verdicts and
// keeps level, expected number, strikes and best score.
// Ports:
//   clk, iResetn                       - clock, async active-low reset
//   iStart, iMouseClick                - start/restart request, raw click
//   iDoneLoad                          - datapath finished placing numbers
//   iChoseCorrectNum, iChoseWrongNum   - datapath verdict levels
//   oResetBoard, oLoadEnable           - board clear strobe, placement enable
//   oShowEnable, oMouseClick           - numbers visible, gated click pulse
//   oLevel, oNumToChoose               - current level, next expected number
//   oStrikes, oScore, oGameOver        - failed rounds, best level, game end
//   oState                             - FSM state encoding
// Every output comes straight from a flop.
module chimp_take2_control
    import chimp_pkg::*;
#(
    parameter int unsigned START_LEVEL    = DEF_START_LEVEL,
    parameter int unsigned MAX_LEVEL      = DEF_MAX_LEVEL,
    parameter int unsigned MAX_STRIKES    = DEF_MAX_STRIKES,
    parameter int unsigned LOAD_TIMEOUT   = DEF_LOAD_TIMEOUT,
    parameter int unsigned RESULT_TIMEOUT = DEF_RESULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               iResetn,
    input  logic               iStart,
    input  logic               iMouseClick,
    input  logic               iDoneLoad,
    input  logic               iChoseCorrectNum,
    input  logic               iChoseWrongNum,
    output logic               oResetBoard,
    output logic               oLoadEnable,
    output logic               oShowEnable,
    output logic               oMouseClick,
    output logic [4:0]         oLevel,
    output logic [4:0]         oNumToChoose,
    output logic [1:0]         oStrikes,
    output logic [5:0]         oScore,
    output logic               oGameOver,
    output logic [STATE_W-1:0] oState
);

    localparam logic [4:0]         LVL_START   = 5'(START_LEVEL);
    localparam logic [4:0]         LVL_MAX     = 5'(MAX_LEVEL);
    localparam logic [1:0]         STRIKE_MAX  = 2'(MAX_STRIKES);
    localparam logic [TIMER_W-1:0] LOAD_LAST   = TIMER_W'(LOAD_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_TIMEOUT - 1);

    logic start_rise, click_rise, correct_rise, wrong_rise;

    chimp_edge_detect u_start_edge   (.clk_i(clk), .rst_ni(iResetn), .d_i(iStart),           .rise_o(start_rise));
    chimp_edge_detect u_click_edge   (.clk_i(clk), .rst_ni(iResetn), .d_i(iMouseClick),      .rise_o(click_rise));
    chimp_edge_detect u_correct_edge (.clk_i(clk), .rst_ni(iResetn), .d_i(iChoseCorrectNum), .rise_o(correct_rise));
    chimp_edge_detect u_wrong_edge   (.clk_i(clk), .rst_ni(iResetn), .d_i(iChoseWrongNum),   .rise_o(wrong_rise));

    state_e             state_q, state_d;
    logic [4:0]         level_q, level_d;
    logic [4:0]         num_q, num_d;
    logic [1:0]         strikes_q, strikes_d;
    logic [5:0]         score_q, score_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               click_q, click_d;
    logic               reset_board_q, load_en_q, show_en_q, game_over_q;
    logic               restart;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        num_d     = num_q;
        strikes_d = strikes_q;
        score_d   = score_q;
        // A restart while already in CLEAR is a no-op, which keeps the
        // board-clear strobe exactly one cycle long.
        restart = start_rise && (state_q != ST_IDLE) && (state_q != ST_GAME_OVER)
                  && (state_q != ST_CLEAR);

        if (restart) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        level_d   = LVL_START;
                        strikes_d = 2'd0;
                        score_d   = 6'd0;
                        state_d   = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    num_d   = 5'd1;
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (iDoneLoad)                  state_d = ST_SHOW;
                    else if (timer_q == LOAD_LAST)  state_d = ST_CLEAR;
                end
                ST_SHOW, ST_HIDDEN: begin
                    if (click_q) state_d = ST_RESULT;
                end
                ST_RESULT: begin
                    // Wrong is checked first so a simultaneous pair fails the round.
                    if (wrong_rise) begin
                        state_d = ST_ROUND_FAIL;
                    end else if (correct_rise) begin
                        if (num_q == level_q) begin
                            state_d = ST_ROUND_WIN;
                        end else begin
                            num_d   = num_q + 5'd1;
                            state_d = ST_HIDDEN;
                        end
                    end else if (timer_q == RESULT_LAST) begin
                        state_d = ST_ROUND_FAIL;
                    end
                end
                ST_ROUND_WIN: begin
                    if ({1'b0, level_q} > score_q) score_d = {1'b0, level_q};
                    level_d = (level_q >= LVL_MAX) ? LVL_MAX : level_q + 5'd1;
                    state_d = ST_CLEAR;
                end
                ST_ROUND_FAIL: begin
                    strikes_d = strikes_q + 2'd1;
                    state_d   = (strikes_d == STRIKE_MAX) ? ST_GAME_OVER : ST_CLEAR;
                end
                ST_GAME_OVER: begin
                    if (start_rise) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Dwell counter restarts on every state change.
        timer_d = (state_d == state_q) ? timer_q + TIMER_W'(1) : '0;
        // Forward a click only while the player phase continues next cycle.
        click_d = click_rise && ((state_q == ST_SHOW) || (state_q == ST_HIDDEN))
                  && (state_d == state_q);
    end

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state_q       <= ST_IDLE;
            level_q       <= LVL_START;
            num_q         <= 5'd1;
            strikes_q     <= 2'd0;
            score_q       <= 6'd0;
            timer_q       <= '0;
            click_q       <= 1'b0;
            reset_board_q <= 1'b0;
            load_en_q     <= 1'b0;
            show_en_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            num_q         <= num_d;
            strikes_q     <= strikes_d;
            score_q       <= score_d;
            timer_q       <= timer_d;
            click_q       <= click_d;
            // Strobes are decoded from the next state so they line up with oState.
            reset_board_q <= (state_d == ST_CLEAR);
            load_en_q     <= (state_d == ST_LOAD);
            show_en_q     <= (state_d == ST_SHOW);
            game_over_q   <= (state_d == ST_GAME_OVER);
        end
    end

    assign oResetBoard  = reset_board_q;
    assign oLoadEnable  = load_en_q;
    assign oShowEnable  = show_en_q;
    assign oMouseClick  = click_q;
    assign oLevel       = level_q;
    assign oNumToChoose = num_q;
    assign oStrikes     = strikes_q;
    assign oScore       = score_q;
    assign oGameOver    = game_over_q;
    assign oState       = state_q;

endmodule

// File: tb/tb_chimp_take2_control.sv
module tb_chimp_take2_control;

    localparam logic [3:0] S_IDLE = 4'd0, S_CLEAR = 4'd1, S_LOAD = 4'd2, S_SHOW = 4'd3,
                           S_HIDDEN = 4'd4, S_RESULT = 4'd5, S_WIN = 4'd6, S_FAIL = 4'd7,
                           S_OVER = 4'd8;

    logic       clk;
    logic       iResetn, iStart, iMouseClick, iDoneLoad, iChoseCorrectNum, iChoseWrongNum;
    logic       oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver;
    logic [4:0] oLevel, oNumToChoose;
    logic [1:0] oStrikes;
    logic [5:0] oScore;
    logic [3:0] oState;

    int total = 0;
    int bad   = 0;

    chimp_take2_control dut (
        .clk(clk), .iResetn(iResetn), .iStart(iStart), .iMouseClick(iMouseClick),
        .iDoneLoad(iDoneLoad), .iChoseCorrectNum(iChoseCorrectNum),
        .iChoseWrongNum(iChoseWrongNum), .oResetBoard(oResetBoard),
        .oLoadEnable(oLoadEnable), .oShowEnable(oShowEnable), .oMouseClick(oMouseClick),
        .oLevel(oLevel), .oNumToChoose(oNumToChoose), .oStrikes(oStrikes),
        .oScore(oScore), .oGameOver(oGameOver), .oState(oState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        iStart = 1'b1; tick(); iStart = 1'b0;
    endtask

    task automatic load_board();
        iDoneLoad = 1'b1; tick(); iDoneLoad = 1'b0;
    endtask

    // v: 0 correct, 1 wrong, 2 both, other none. Ends one cycle after the verdict.
    task automatic click_verdict(input int v);
        iMouseClick = 1'b1; tick(); iMouseClick = 1'b0; tick();
        if (v == 0 || v == 2) iChoseCorrectNum = 1'b1;
        if (v == 1 || v == 2) iChoseWrongNum = 1'b1;
        tick();
        iChoseCorrectNum = 1'b0; iChoseWrongNum = 1'b0;
    endtask

    // From LOAD: win a round at level lvl, ending in LOAD of the next round.
    task automatic win_round(input int lvl);
        load_board();
        for (int k = 0; k < lvl; k++) click_verdict(0);
        tick(); tick();
    endtask

    task automatic test_reset();
        iResetn = 1'b0; iStart = 1'b0; iMouseClick = 1'b0; iDoneLoad = 1'b0;
        iChoseCorrectNum = 1'b0; iChoseWrongNum = 1'b0;
        #12;
        total++; if (oState !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", oState, S_IDLE); end
        total++; if (oLevel !== 5'd4) begin bad++; $display("FAIL reset_level got=%0d exp=4", oLevel); end
        total++; if (oNumToChoose !== 5'd1) begin bad++; $display("FAIL reset_num got=%0d exp=1", oNumToChoose); end
        total++; if ({oStrikes, oScore} !== 8'd0) begin bad++; $display("FAIL reset_strikes_score got=%0d/%0d exp=0/0", oStrikes, oScore); end
        total++; if ({oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver} !== 5'd0)
            begin bad++; $display("FAIL reset_strobes got=%b exp=00000", {oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver}); end
        @(posedge clk); #1; iResetn = 1'b1;
        tick(); tick();
    endtask

    task automatic test_win();
        pulse_start();
        total++; if (oState !== S_CLEAR || oResetBoard !== 1'b1) begin bad++; $display("FAIL win_clear got=%0d/%b exp=%0d/1", oState, oResetBoard, S_CLEAR); end
        total++; if (oLevel !== 5'd4) begin bad++; $display("FAIL win_start_level got=%0d exp=4", oLevel); end
        tick();
        total++; if (oState !== S_LOAD || oLoadEnable !== 1'b1 || oResetBoard !== 1'b0)
            begin bad++; $display("FAIL win_load got=%0d/%b/%b exp=%0d/1/0", oState, oLoadEnable, oResetBoard, S_LOAD); end
        total++; if (oNumToChoose !== 5'd1) begin bad++; $display("FAIL win_num1 got=%0d exp=1", oNumToChoose); end
        load_board();
        total++; if (oState !== S_SHOW || oShowEnable !== 1'b1) begin bad++; $display("FAIL win_show got=%0d/%b exp=%0d/1", oState, oShowEnable, S_SHOW); end
        iMouseClick = 1'b1; tick();
        total++; if (oMouseClick !== 1'b1) begin bad++; $display("FAIL win_click_pulse got=%b exp=1", oMouseClick); end
        iMouseClick = 1'b0; tick();
        total++; if (oState !== S_RESULT || oMouseClick !== 1'b0) begin bad++; $display("FAIL win_result got=%0d/%b exp=%0d/0", oState, oMouseClick, S_RESULT); end
        iChoseCorrectNum = 1'b1; tick(); iChoseCorrectNum = 1'b0;
        total++; if (oState !== S_HIDDEN || oNumToChoose !== 5'd2 || oShowEnable !== 1'b0)
            begin bad++; $display("FAIL win_hidden got=%0d/%0d/%b exp=%0d/2/0", oState, oNumToChoose, oShowEnable, S_HIDDEN); end
        for (int k = 0; k < 3; k++) click_verdict(0);
        total++; if (oState !== S_WIN) begin bad++; $display("FAIL win_round_win got=%0d exp=%0d", oState, S_WIN); end
        tick();
        total++; if (oLevel !== 5'd5 || oScore !== 6'd4 || oResetBoard !== 1'b1)
            begin bad++; $display("FAIL win_update got=%0d/%0d/%b exp=5/4/1", oLevel, oScore, oResetBoard); end
        tick();
        total++; if (oResetBoard !== 1'b0 || oState !== S_LOAD) begin bad++; $display("FAIL win_one_pulse got=%b/%0d exp=0/%0d", oResetBoard, oState, S_LOAD); end
    endtask

    task automatic test_load_timeout();
        repeat (1023) tick();
        total++; if (oState !== S_LOAD) begin bad++; $display("FAIL ldto_still_load got=%0d exp=%0d", oState, S_LOAD); end
        tick();
        total++; if (oState !== S_CLEAR || oStrikes !== 2'd0) begin bad++; $display("FAIL ldto_retry got=%0d/%0d exp=%0d/0", oState, oStrikes, S_CLEAR); end
        tick();
    endtask

    task automatic test_result_timeout();
        load_board();
        iMouseClick = 1'b1; tick(); iMouseClick = 1'b0; tick();
        repeat (7) tick();
        total++; if (oState !== S_RESULT) begin bad++; $display("FAIL rsto_wait got=%0d exp=%0d", oState, S_RESULT); end
        tick();
        total++; if (oState !== S_FAIL) begin bad++; $display("FAIL rsto_fail got=%0d exp=%0d", oState, S_FAIL); end
        tick();
        total++; if (oState !== S_CLEAR || oStrikes !== 2'd1 || oLevel !== 5'd5)
            begin bad++; $display("FAIL rsto_strike got=%0d/%0d/%0d exp=%0d/1/5", oState, oStrikes, oLevel, S_CLEAR); end
        tick();
    endtask

    task automatic test_simultaneous();
        load_board();
        click_verdict(2);
        total++; if (oState !== S_FAIL) begin bad++; $display("FAIL simul_fail got=%0d exp=%0d", oState, S_FAIL); end
        tick();
        total++; if (oStrikes !== 2'd2) begin bad++; $display("FAIL simul_strikes got=%0d exp=2", oStrikes); end
        tick();
    endtask

    task automatic test_restart();
        load_board();
        click_verdict(0);
        total++; if (oState !== S_HIDDEN || oNumToChoose !== 5'd2) begin bad++; $display("FAIL rst_hidden got=%0d/%0d exp=%0d/2", oState, oNumToChoose, S_HIDDEN); end
        pulse_start();
        total++; if (oState !== S_CLEAR || oStrikes !== 2'd2 || oScore !== 6'd4 || oLevel !== 5'd5)
            begin bad++; $display("FAIL restart_keep got=%0d/%0d/%0d/%0d exp=%0d/2/4/5", oState, oStrikes, oScore, oLevel, S_CLEAR); end
        tick();
        total++; if (oState !== S_LOAD || oNumToChoose !== 5'd1) begin bad++; $display("FAIL restart_load got=%0d/%0d exp=%0d/1", oState, oNumToChoose, S_LOAD); end
    endtask

    task automatic test_game_over();
        load_board();
        click_verdict(1);
        tick();
        total++; if (oState !== S_OVER || oGameOver !== 1'b1 || oStrikes !== 2'd3)
            begin bad++; $display("FAIL over_enter got=%0d/%b/%0d exp=%0d/1/3", oState, oGameOver, oStrikes, S_OVER); end
        iMouseClick = 1'b1; tick();
        total++; if (oMouseClick !== 1'b0) begin bad++; $display("FAIL over_click_drop got=%b exp=0", oMouseClick); end
        iMouseClick = 1'b0; tick();
        pulse_start();
        total++; if (oState !== S_IDLE || oGameOver !== 1'b0) begin bad++; $display("FAIL over_to_idle got=%0d/%b exp=%0d/0", oState, oGameOver, S_IDLE); end
        tick();
    endtask

    task automatic test_fail();
        pulse_start();
        total++; if (oLevel !== 5'd4 || oStrikes !== 2'd0 || oScore !== 6'd0)
            begin bad++; $display("FAIL fail_newgame got=%0d/%0d/%0d exp=4/0/0", oLevel, oStrikes, oScore); end
        tick();
        for (int r = 1; r <= 3; r++) begin
            load_board();
            click_verdict(1);
            total++; if (oState !== S_FAIL) begin bad++; $display("FAIL fail_round%0d got=%0d exp=%0d", r, oState, S_FAIL); end
            tick();
            total++; if (oStrikes !== 2'(r) || oState !== ((r == 3) ? S_OVER : S_CLEAR))
                begin bad++; $display("FAIL fail_after%0d got=%0d/%0d exp=%0d/%0d", r, oStrikes, oState, r, (r == 3) ? S_OVER : S_CLEAR); end
            if (r < 3) tick();
        end
        total++; if (oGameOver !== 1'b1) begin bad++; $display("FAIL fail_gameover got=%b exp=1", oGameOver); end
        pulse_start();
        total++; if (oState !== S_IDLE) begin bad++; $display("FAIL fail_to_idle got=%0d exp=%0d", oState, S_IDLE); end
        tick();
    endtask

    task automatic test_saturation();
        pulse_start(); tick();
        for (int lvl = 4; lvl <= 24; lvl++) win_round(lvl);
        total++; if (oLevel !== 5'd25 || oScore !== 6'd24) begin bad++; $display("FAIL sat_reach got=%0d/%0d exp=25/24", oLevel, oScore); end
        win_round(25);
        total++; if (oLevel !== 5'd25 || oScore !== 6'd25) begin bad++; $display("FAIL sat_hold got=%0d/%0d exp=25/25", oLevel, oScore); end
    endtask

    task automatic test_midround_reset();
        load_board();
        click_verdict(0);
        total++; if (oState !== S_HIDDEN) begin bad++; $display("FAIL mrr_hidden got=%0d exp=%0d", oState, S_HIDDEN); end
        iMouseClick = 1'b1; iStart = 1'b1;
        #2; iResetn = 1'b0; #1;
        total++; if (oState !== S_IDLE || oLevel !== 5'd4 || oNumToChoose !== 5'd1 || oStrikes !== 2'd0 || oScore !== 6'd0)
            begin bad++; $display("FAIL mrr_values got=%0d/%0d/%0d/%0d/%0d exp=0/4/1/0/0", oState, oLevel, oNumToChoose, oStrikes, oScore); end
        total++; if ({oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver} !== 5'd0)
            begin bad++; $display("FAIL mrr_strobes got=%b exp=00000", {oResetBoard, oLoadEnable, oShowEnable, oMouseClick, oGameOver}); end
        tick(); tick();
        iResetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (oMouseClick !== 1'b0 || oState !== S_IDLE)
                begin bad++; $display("FAIL mrr_held_c%0d got=%b/%0d exp=0/%0d", c, oMouseClick, oState, S_IDLE); end
        end
        iMouseClick = 1'b0; iStart = 1'b0; tick();
        pulse_start();
        total++; if (oState !== S_CLEAR) begin bad++; $display("FAIL mrr_restart got=%0d exp=%0d", oState, S_CLEAR); end
    endtask

    initial begin
        test_reset();
        test_win();
        test_load_timeout();
        test_result_timeout();
        test_simultaneous();
        test_restart();
        test_game_over();
        test_fail();
        test_saturation();
        test_midround_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
